// File: rtl/inv_round_sequencer.sv
// -----------------------------------------------------------------------------
// inv_round_sequencer
// Iterative AES inverse-cipher round sequencer with the AddRoundKey stage.
// One 128-bit block is processed at a time. The block is whitened with round
// key NR on acceptance. It then takes NR round cycles through the external
// InvShiftRows/InvSubBytes and InvMixColumns datapaths. The plaintext is held
// until the downstream side takes it.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   i_in_valid      ciphertext block offered
//   o_in_ready      block accepted this cycle if offered (IDLE only)
//   i_in_data       ciphertext, byte 0 = bits [0:7]
//   o_key_idx       round-key index requested this cycle
//   i_round_key     round key for o_key_idx (combinational, same cycle)
//   o_isb_din       state register to the InvShiftRows/InvSubBytes path
//   i_isb_dout      result of that path (combinational)
//   o_imc_din       i_isb_dout ^ i_round_key, to InvMixColumns
//   o_imc_bypass    InvMixColumns bypass, high in the final round
//   i_imc_dout      InvMixColumns result (combinational)
//   o_out_valid     plaintext available
//   i_out_ready     downstream accepts plaintext
//   o_out_data      plaintext (state register)
//   o_busy          sequencer not idle
// -----------------------------------------------------------------------------
module inv_round_sequencer #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [0:127]      i_in_data,
    output logic [KIDX_W-1:0] o_key_idx,
    input  logic [0:127]      i_round_key,
    output logic [0:127]      o_isb_din,
    input  logic [0:127]      i_isb_dout,
    output logic [0:127]      o_imc_din,
    output logic              o_imc_bypass,
    input  logic [0:127]      i_imc_dout,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [0:127]      o_out_data,
    output logic              o_busy
);

    // Round-counter landmarks
    localparam logic [KIDX_W-1:0] K_LAST  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] K_FIRST = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] K_ONE   = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] K_ZERO  = {KIDX_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    fsm_t              r_fsm;
    logic [0:127]      r_state;
    logic [KIDX_W-1:0] r_round;
    logic [KIDX_W-1:0] r_key_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_bypass;

    logic [0:127]      w_init_state;
    logic [0:127]      w_add_key;

    // Initial whitening uses the key fetched while idle (index NR).
    assign w_init_state = i_in_data ^ i_round_key;
    // AddRoundKey sits between the ISR/ISB path and InvMixColumns.
    assign w_add_key    = i_isb_dout ^ i_round_key;

    assign o_isb_din    = r_state;
    assign o_imc_din    = w_add_key;
    assign o_out_data   = r_state;
    assign o_key_idx    = r_key_idx;
    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;
    assign o_imc_bypass = r_bypass;

    // Sequencer FSM; every output flag is registered alongside the state so it
    // is glitch-free. The key index is pre-computed for the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= {128{1'b0}};
            r_round     <= K_ZERO;
            r_key_idx   <= K_LAST;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bypass    <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_state    <= w_init_state;
                        r_round    <= K_FIRST;
                        r_key_idx  <= K_FIRST;
                        r_bypass   <= (K_FIRST == K_ZERO);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= S_ROUND;
                    end else begin
                        r_key_idx  <= K_LAST;
                        r_bypass   <= 1'b0;
                    end
                end
                S_ROUND: begin
                    r_state <= i_imc_dout;
                    if (r_round == K_ZERO) begin
                        // Final round done; park the key index for the next block.
                        r_fsm       <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_bypass    <= 1'b0;
                        r_key_idx   <= K_LAST;
                    end else begin
                        // Decrement only while nonzero so the counter never wraps.
                        r_round   <= r_round - K_ONE;
                        r_key_idx <= r_round - K_ONE;
                        r_bypass  <= (r_round == K_ONE);
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_key_idx   <= K_LAST;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    // Illegal encoding: return to a clean idle state.
                    r_fsm       <= S_IDLE;
                    r_round     <= K_ZERO;
                    r_key_idx   <= K_LAST;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_bypass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inv_round_sequencer
// Self-checking bench for inv_round_sequencer. It builds two instances, one
// with NR=10 (AES-128) and one with NR=14 (AES-256). The bench provides the
// external key ROM, the InvShiftRows/InvSubBytes path and InvMixColumns, all
// computed from GF(2^8) arithmetic. A whole-block AES decryption model gives
// the expected plaintexts.
// -----------------------------------------------------------------------------
module tb_inv_round_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_accept = 0;

    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];

    // ---------------- GF(2^8) / AES helper functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, base, e;
        r = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = s;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = s;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
        end
        return o;
    endfunction

    // Key schedule: fills the round-key ROM of the instance with this NR.
    task automatic expand(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nw;
        nk = nr - 6;
        nw = 4 * (nr + 1);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nr == 10) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else          rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] rk(input int nr, input int i);
        return (nr == 10) ? rk10[i] : rk14[i];
    endfunction

    // Whole-block inverse cipher (straight FIPS-197 InvCipher loop).
    function automatic logic [127:0] ref_dec(input int nr, input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk(nr, nr);
        for (int r = nr - 1; r >= 0; r--) begin
            s = inv_sub(inv_shift(s)) ^ rk(nr, r);
            if (r != 0) s = inv_mix(s);
        end
        return s;
    endfunction

    // ---------------- DUT instances and their environments ----------------
    logic         a_in_valid, a_in_ready, a_imc_bypass, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_round_key, a_isb_din, a_isb_dout, a_imc_din, a_imc_dout, a_out_data;
    logic [3:0]   a_key_idx;
    logic         b_in_valid, b_in_ready, b_imc_bypass, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_round_key, b_isb_din, b_isb_dout, b_imc_din, b_imc_dout, b_out_data;
    logic [3:0]   b_key_idx;

    assign a_round_key = rk10[a_key_idx];
    assign a_isb_dout  = inv_sub(inv_shift(a_isb_din));
    assign a_imc_dout  = a_imc_bypass ? a_imc_din : inv_mix(a_imc_din);
    assign b_round_key = rk14[b_key_idx];
    assign b_isb_dout  = inv_sub(inv_shift(b_isb_din));
    assign b_imc_dout  = b_imc_bypass ? b_imc_din : inv_mix(b_imc_din);

    inv_round_sequencer #(.NR(10), .KIDX_W(4)) dut10 (
        .clk(clk), .rst(rst),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .o_key_idx(a_key_idx), .i_round_key(a_round_key),
        .o_isb_din(a_isb_din), .i_isb_dout(a_isb_dout),
        .o_imc_din(a_imc_din), .o_imc_bypass(a_imc_bypass), .i_imc_dout(a_imc_dout),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
        .o_busy(a_busy)
    );

    inv_round_sequencer #(.NR(14), .KIDX_W(4)) dut14 (
        .clk(clk), .rst(rst),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .o_key_idx(b_key_idx), .i_round_key(b_round_key),
        .o_isb_din(b_isb_din), .i_isb_dout(b_isb_dout),
        .o_imc_din(b_imc_din), .o_imc_bypass(b_imc_bypass), .i_imc_dout(b_imc_dout),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_busy(b_busy)
    );

    // ---------------- per-instance access ----------------
    function automatic logic g_in_ready(input int nr);  return (nr == 10) ? a_in_ready   : b_in_ready;   endfunction
    function automatic logic g_out_valid(input int nr); return (nr == 10) ? a_out_valid  : b_out_valid;  endfunction
    function automatic logic g_busy(input int nr);      return (nr == 10) ? a_busy       : b_busy;       endfunction
    function automatic logic g_bypass(input int nr);    return (nr == 10) ? a_imc_bypass : b_imc_bypass; endfunction
    function automatic logic [3:0] g_key_idx(input int nr);    return (nr == 10) ? a_key_idx  : b_key_idx;  endfunction
    function automatic logic [127:0] g_out_data(input int nr); return (nr == 10) ? a_out_data : b_out_data; endfunction

    task automatic drive(input int nr, input logic v, input logic [127:0] d);
        if (nr == 10) begin a_in_valid = v; a_in_data = d; end
        else          begin b_in_valid = v; b_in_data = d; end
    endtask

    task automatic set_ready(input int nr, input logic r);
        if (nr == 10) a_out_ready = r;
        else          b_out_ready = r;
    endtask

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    // One block end to end. It checks the key order, the bypass, the latency,
    // the plaintext, the hold behaviour and the return to IDLE.
    task automatic run_block(input int nr, input logic [127:0] ct, input logic [127:0] exp,
                             input int hold, input bit inject, input string tag);
        int waited;
        logic [3:0] ek;
        waited = 0;
        while (g_in_ready(nr) !== 1'b1 && waited < 40) begin
            @(posedge clk); #1; waited++;
        end
        n_tests++;
        if (g_in_ready(nr) !== 1'b1) begin
            n_fail++; $display("FAIL %s in_ready: got %b, want 1 within 40 cycles", tag, g_in_ready(nr));
            return;
        end
        n_tests++;
        if (g_key_idx(nr) !== 4'(nr)) begin
            n_fail++; $display("FAIL %s key_idx_idle: got %0d, want %0d", tag, g_key_idx(nr), nr);
        end
        drive(nr, 1'b1, ct);
        @(posedge clk); #1;
        last_accept = cyc;
        drive(nr, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        for (int j = 0; j < nr; j++) begin
            ek = 4'(nr - 1 - j);
            n_tests++;
            if (g_out_valid(nr) !== 1'b0) begin
                n_fail++; $display("FAIL %s early_valid: got %b at round step %0d, want 0", tag, g_out_valid(nr), j);
            end
            n_tests++;
            if (g_key_idx(nr) !== ek) begin
                n_fail++; $display("FAIL %s key_idx: got %0d, want %0d", tag, g_key_idx(nr), ek);
            end
            n_tests++;
            if (g_bypass(nr) !== ((ek == 4'd0) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL %s bypass: got %b at key_idx %0d", tag, g_bypass(nr), ek);
            end
            n_tests++;
            if (g_in_ready(nr) !== 1'b0 || g_busy(nr) !== 1'b1) begin
                n_fail++; $display("FAIL %s round_flags: in_ready=%b busy=%b, want 0/1", tag, g_in_ready(nr), g_busy(nr));
            end
            if (inject && j == 2) drive(nr, 1'b1, {$urandom, $urandom, $urandom, $urandom});
            else if (inject && j == 3) drive(nr, 1'b0, 128'h0);
            @(posedge clk); #1;
        end
        n_tests++;
        if (g_out_valid(nr) !== 1'b1) begin
            n_fail++; $display("FAIL %s latency: out_valid=%b after %0d edges, want 1", tag, g_out_valid(nr), nr);
        end
        n_tests++;
        if (g_out_data(nr) !== exp) begin
            n_fail++; $display("FAIL %s out_data: got %h, want %h", tag, g_out_data(nr), exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_tests++;
            if (g_out_valid(nr) !== 1'b1 || g_out_data(nr) !== exp || g_in_ready(nr) !== 1'b0) begin
                n_fail++; $display("FAIL %s hold: valid=%b in_ready=%b data=%h, want 1/0/%h",
                                   tag, g_out_valid(nr), g_in_ready(nr), g_out_data(nr), exp);
            end
        end
        set_ready(nr, 1'b1);
        @(posedge clk); #1;
        set_ready(nr, 1'b0);
        n_tests++;
        if (g_out_valid(nr) !== 1'b0 || g_in_ready(nr) !== 1'b1 || g_busy(nr) !== 1'b0) begin
            n_fail++; $display("FAIL %s release: valid=%b in_ready=%b busy=%b, want 0/1/0",
                               tag, g_out_valid(nr), g_in_ready(nr), g_busy(nr));
        end
        if (inject) begin
            @(posedge clk); #1;
            n_tests++;
            if (g_busy(nr) !== 1'b0) begin
                n_fail++; $display("FAIL %s ignored_pulse: busy=%b after release, want 0", tag, g_busy(nr));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            int nr;
            nr = (k == 0) ? 10 : 14;
            n_tests++;
            if (g_in_ready(nr) !== 1'b1 || g_out_valid(nr) !== 1'b0 || g_busy(nr) !== 1'b0 || g_bypass(nr) !== 1'b0) begin
                n_fail++; $display("FAIL reset_flags nr%0d: in_ready=%b valid=%b busy=%b bypass=%b, want 1/0/0/0",
                                   nr, g_in_ready(nr), g_out_valid(nr), g_busy(nr), g_bypass(nr));
            end
            n_tests++;
            if (g_out_data(nr) !== 128'h0 || g_key_idx(nr) !== 4'(nr)) begin
                n_fail++; $display("FAIL reset_data nr%0d: data=%h key_idx=%0d, want 0/%0d",
                                   nr, g_out_data(nr), g_key_idx(nr), nr);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_kat();
        run_block(10, CT128, PT, 0, 1'b0, "kat128");
        run_block(14, CT256, PT, 0, 1'b0, "kat256");
    endtask

    task automatic test_done_hold();
        run_block(10, CT128, PT, 5, 1'b0, "hold5");
    endtask

    task automatic test_ignore_in_valid();
        run_block(10, CT128, PT, 1, 1'b1, "ignore10");
        run_block(14, CT256, PT, 0, 1'b1, "ignore14");
    endtask

    task automatic test_back_to_back();
        int a1;
        for (int k = 0; k < 2; k++) begin
            int nr;
            nr = (k == 0) ? 10 : 14;
            run_block(nr, (nr == 10) ? CT128 : CT256, PT, 0, 1'b0, "b2b_first");
            a1 = last_accept;
            run_block(nr, (nr == 10) ? CT128 : CT256, PT, 0, 1'b0, "b2b_second");
            n_tests++;
            if (last_accept - a1 !== nr + 2) begin
                n_fail++; $display("FAIL b2b_period nr%0d: got %0d cycles, want %0d", nr, last_accept - a1, nr + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        drive(10, 1'b1, CT128);
        @(posedge clk); #1;
        drive(10, 1'b0, 128'h0);
        waited = 0;
        while (a_key_idx !== 4'd5 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        n_tests++;
        if (a_key_idx !== 4'd5) begin
            n_fail++; $display("FAIL midreset_reach: key_idx=%0d, want 5 within 20 cycles", a_key_idx);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_imc_bypass !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flags: in_ready=%b valid=%b busy=%b bypass=%b, want 1/0/0/0",
                               a_in_ready, a_out_valid, a_busy, a_imc_bypass);
        end
        n_tests++;
        if (a_out_data !== 128'h0 || a_key_idx !== 4'd10) begin
            n_fail++; $display("FAIL midreset_data: data=%h key_idx=%0d, want 0/10", a_out_data, a_key_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_block(10, CT128, PT, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] ct, exp;
        int nr;
        for (int i = 0; i < 8; i++) begin
            nr  = ($urandom_range(0, 1) == 1) ? 14 : 10;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (nr == 10) key[127:0] = 128'h0;
            expand(key, nr);
            ct  = {$urandom, $urandom, $urandom, $urandom};
            exp = ref_dec(nr, ct);
            run_block(nr, ct, exp, $urandom_range(0, 3), ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 128'h0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 128'h0; b_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin rk10[i] = 128'h0; rk14[i] = 128'h0; end
        expand(KEY128, 10);
        expand(KEY256, 14);
        test_reset();
        test_kat();
        test_done_hold();
        test_ignore_in_valid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
